// File: rtl/lift_request_scheduler.sv
// SCAN-ordered call scheduler for a single-car lift: latches floor calls, dispatches
// one target at a time to the lift controller and holds the door for a fixed dwell.
module lift_request_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_FLOORS-1:0] req_i,
  input  logic                  arrived_i,
  input  logic [FLOOR_W-1:0]    at_floor_i,
  output logic [FLOOR_W-1:0]    target_floor_o,
  output logic                  target_valid_o,
  output logic                  door_open_o,
  output logic [FLOOR_W-1:0]    cur_floor_o,
  output logic                  dir_up_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  err_o
);

  localparam int               CNT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [CNT_W-1:0] DWELL = CNT_W'(DOOR_CYCLES);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR} state_t;

  state_t                state;
  logic [CNT_W-1:0]      door_cnt;

  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] tgt_mask;
  logic [NUM_FLOORS-1:0] set_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] pending_next;
  logic                  above_found;
  logic                  below_found;
  logic [FLOOR_W-1:0]    above_idx;
  logic [FLOOR_W-1:0]    below_idx;
  logic                  arrive_match;
  logic                  at_in_range;

  assign cur_mask     = NUM_FLOORS'(1) << cur_floor_o;
  assign tgt_mask     = NUM_FLOORS'(1) << target_floor_o;
  assign arrive_match = arrived_i && (at_floor_i == target_floor_o);
  assign at_in_range  = int'(at_floor_i) < NUM_FLOORS;

  // Nearest pending floor strictly above and strictly below the car.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    above_found = 1'b0;
    above_idx   = '0;
    below_found = 1'b0;
    below_idx   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_o[i] && (i > int'(cur_floor_o))) begin
        above_found = 1'b1;
        above_idx   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_o[i] && (i < int'(cur_floor_o))) begin
        below_found = 1'b1;
        below_idx   = FLOOR_W'(i);
      end
    end
  end

  // Clear beats a same-cycle set; a call for the open-door floor is absorbed.
  always_comb begin
    set_mask   = req_i;
    clear_mask = '0;
    case (state)
      IDLE:    if (|(pending_o & cur_mask)) clear_mask = cur_mask;
      MOVING:  if (arrive_match) clear_mask = tgt_mask;
      DOOR:    set_mask = req_i & ~cur_mask;
      default: ;
    endcase
    pending_next = (pending_o | set_mask) & ~clear_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      door_cnt       <= '0;
      cur_floor_o    <= '0;
      dir_up_o       <= 1'b1;
      pending_o      <= '0;
      target_floor_o <= '0;
      target_valid_o <= 1'b0;
      door_open_o    <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      pending_o <= pending_next;
      case (state)
        IDLE: begin
          if (|(pending_o & cur_mask)) begin
            state       <= DOOR;
            door_open_o <= 1'b1;
            door_cnt    <= DWELL;
          end else if (dir_up_o ? above_found : below_found) begin
            state          <= MOVING;
            target_valid_o <= 1'b1;
            target_floor_o <= dir_up_o ? above_idx : below_idx;
          end else if (dir_up_o ? below_found : above_found) begin
            dir_up_o       <= ~dir_up_o;
            state          <= MOVING;
            target_valid_o <= 1'b1;
            target_floor_o <= dir_up_o ? below_idx : above_idx;
          end
        end
        MOVING: begin
          if (arrived_i) begin
            target_valid_o <= 1'b0;
            if (arrive_match) begin
              cur_floor_o <= target_floor_o;
              state       <= DOOR;
              door_open_o <= 1'b1;
              door_cnt    <= DWELL;
            end else begin
              err_o <= 1'b1;
              if (at_in_range) cur_floor_o <= at_floor_i;
              state <= IDLE;
            end
          end
        end
        DOOR: begin
          if (|(req_i & cur_mask)) begin
            door_cnt <= DWELL;
          end else if (door_cnt == CNT_W'(1)) begin
            state       <= IDLE;
            door_open_o <= 1'b0;
          end else begin
            door_cnt <= door_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Directed bench for lift_request_scheduler: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_lift_request_scheduler;

  localparam int NUM_FLOORS  = 8;
  localparam int FLOOR_W     = 3;
  localparam int DOOR_CYCLES = 4;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NUM_FLOORS-1:0] req_i;
  logic                  arrived_i;
  logic [FLOOR_W-1:0]    at_floor_i;
  logic [FLOOR_W-1:0]    target_floor_o;
  logic                  target_valid_o;
  logic                  door_open_o;
  logic [FLOOR_W-1:0]    cur_floor_o;
  logic                  dir_up_o;
  logic [NUM_FLOORS-1:0] pending_o;
  logic                  err_o;

  int vectors = 0;
  int errors  = 0;

  lift_request_scheduler #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_i         (req_i),
    .arrived_i     (arrived_i),
    .at_floor_i    (at_floor_i),
    .target_floor_o(target_floor_o),
    .target_valid_o(target_valid_o),
    .door_open_o   (door_open_o),
    .cur_floor_o   (cur_floor_o),
    .dir_up_o      (dir_up_o),
    .pending_o     (pending_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge, then settle 1 ns so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic press(input logic [NUM_FLOORS-1:0] mask);
    req_i = mask;
    tick();
    req_i = '0;
  endtask

  task automatic arrive(input logic [FLOOR_W-1:0] floor);
    arrived_i  = 1'b1;
    at_floor_i = floor;
    tick();
    arrived_i  = 1'b0;
    at_floor_i = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_i      = 1'b1;
    req_i      = '0;
    arrived_i  = 1'b0;
    at_floor_i = '0;
    ticks(2);
    check("rst_cur",     cur_floor_o,    0);
    check("rst_dir",     dir_up_o,       1);
    check("rst_pending", pending_o,      0);
    check("rst_target",  target_floor_o, 0);
    check("rst_valid",   target_valid_o, 0);
    check("rst_door",    door_open_o,    0);
    check("rst_err",     err_o,          0);
    rst_i = 1'b0;
    tick();

    // Single call to floor 5 from floor 0.
    press(8'h20);
    check("t1_pending", pending_o, 8'h20);
    check("t1_valid0", target_valid_o, 0);
    tick();
    check("t1_target", target_floor_o, 5);
    check("t1_valid",  target_valid_o, 1);
    check("t1_dir",    dir_up_o, 1);
    ticks(2);
    check("t1_hold", target_floor_o, 5);
    arrive(5);
    check("t1_cur",      cur_floor_o, 5);
    check("t1_cleared",  pending_o, 0);
    check("t1_door",     door_open_o, 1);
    check("t1_valid_lo", target_valid_o, 0);
    for (int i = 0; i < DOOR_CYCLES - 1; i++) begin
      tick();
      check("t1_dwell", door_open_o, 1);
    end
    tick();
    check("t1_door_end", door_open_o, 0);

    // Floor 3 lies below while sweeping up: direction flips.
    press(8'h08);
    check("t2_pend3", pending_o, 8'h08);
    tick();
    check("t2_tgt3", target_floor_o, 3);
    check("t2_dir3", dir_up_o, 0);
    arrive(3);
    check("t2_cur3", cur_floor_o, 3);
    ticks(DOOR_CYCLES);
    press(8'h40);
    tick();
    check("t2_tgt6", target_floor_o, 6);
    check("t2_dir6", dir_up_o, 1);
    press(8'h02);
    press(8'h10);
    check("t2_no_retarget", target_floor_o, 6);
    check("t2_valid",       target_valid_o, 1);
    check("t2_accum",       pending_o, 8'h52);
    arrive(6);
    check("t2_cur6",   cur_floor_o, 6);
    check("t2_pend6",  pending_o, 8'h12);
    check("t2_door6",  door_open_o, 1);
    check("t2_valid6", target_valid_o, 0);
    ticks(DOOR_CYCLES);
    check("t2_idle_gap", target_valid_o, 0);
    tick();
    check("t2_tgt4", target_floor_o, 4);
    check("t2_dir4", dir_up_o, 0);
    arrive(4);
    check("t2_pend4", pending_o, 8'h02);
    ticks(DOOR_CYCLES + 1);
    check("t2_tgt1", target_floor_o, 1);
    check("t2_dir1", dir_up_o, 0);
    arrive(1);
    check("t2_cur1", cur_floor_o, 1);
    ticks(DOOR_CYCLES);

    // Move to floor 2, then call floor 2 while idle there.
    press(8'h04);
    tick();
    check("t3_tgt2", target_floor_o, 2);
    check("t3_dir2", dir_up_o, 1);
    arrive(2);
    ticks(DOOR_CYCLES);
    press(8'h04);
    check("t3_pend", pending_o, 8'h04);
    check("t3_door_lo", door_open_o, 0);
    tick();
    check("t3_door", door_open_o, 1);
    check("t3_novalid", target_valid_o, 0);
    check("t3_clear", pending_o, 0);
    tick();
    req_i = 8'h04;
    tick();
    req_i = '0;
    check("t3_absorbed", pending_o, 0);
    check("t3_ext_door", door_open_o, 1);
    for (int i = 0; i < DOOR_CYCLES - 1; i++) begin
      tick();
      check("t3_ext_dwell", door_open_o, 1);
    end
    tick();
    check("t3_ext_end", door_open_o, 0);
    tick();
    check("t3_stay_idle", target_valid_o, 0);

    // Arrival at the wrong floor.
    press(8'h20);
    tick();
    check("t4_tgt5", target_floor_o, 5);
    arrive(3);
    check("t4_err",     err_o, 1);
    check("t4_cur",     cur_floor_o, 3);
    check("t4_pend",    pending_o, 8'h20);
    check("t4_valid",   target_valid_o, 0);
    check("t4_door",    door_open_o, 0);
    tick();
    check("t4_redispatch", target_floor_o, 5);
    check("t4_revalid",    target_valid_o, 1);
    check("t4_sticky",     err_o, 1);

    // Reset mid-move with pending 8'h81; the same-cycle call is ignored.
    arrive(5);
    ticks(DOOR_CYCLES);
    press(8'h81);
    check("t5_pend", pending_o, 8'h81);
    tick();
    check("t5_tgt7", target_floor_o, 7);
    check("t5_valid", target_valid_o, 1);
    rst_i = 1'b1;
    req_i = 8'h10;
    tick();
    rst_i = 1'b0;
    req_i = '0;
    check("t5_cur",     cur_floor_o, 0);
    check("t5_dir",     dir_up_o, 1);
    check("t5_pending", pending_o, 0);
    check("t5_target",  target_floor_o, 0);
    check("t5_valid0",  target_valid_o, 0);
    check("t5_door",    door_open_o, 0);
    check("t5_err",     err_o, 0);

    // Arrival and a call for the same floor in one cycle; stray arrival in DOOR.
    press(8'h08);
    tick();
    check("t6_tgt3", target_floor_o, 3);
    arrived_i  = 1'b1;
    at_floor_i = 3'd3;
    req_i      = 8'h08;
    tick();
    arrived_i  = 1'b0;
    at_floor_i = '0;
    req_i      = '0;
    check("t6_pend", pending_o, 0);
    check("t6_door", door_open_o, 1);
    check("t6_cur",  cur_floor_o, 3);
    arrive(6);
    check("t6_ign_cur",  cur_floor_o, 3);
    check("t6_ign_err",  err_o, 0);
    check("t6_ign_door", door_open_o, 1);
    check("t6_pend2",    pending_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
